// File: rtl/mem_access_pkg.sv
// Shared types, funct3 codes and decode helpers for the load/store unit.
package mem_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT0,
    ST_BEAT1,
    ST_DONE
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Access size in bytes: 1, 2, 4 or 8.
  function automatic int unsigned access_size(input logic [2:0] funct3);
    return 32'd1 << funct3[1:0];
  endfunction

  // Whether a width/sign code is a valid load or store for this XLEN.
  function automatic logic is_legal(input logic [2:0] funct3, input logic write,
                                    input int unsigned xlen);
    logic ok;
    case (funct3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_D:             ok = (xlen == 32'd64);
      F3_BU, F3_HU:     ok = !write;
      F3_WU:            ok = !write && (xlen == 32'd64);
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Merges one or two bus beats, aligns to the access offset, truncates and extends.
module load_extend #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]           beat0,
  input  logic [XLEN-1:0]           beat1,
  input  logic [$clog2(XLEN/8)-1:0] offset,
  input  logic [2:0]                funct3,
  output logic [XLEN-1:0]           result
);
  logic [XLEN-1:0] merged;

  // Right-align the accessed bytes, then extend per funct3
  always_comb begin
    merged = XLEN'({beat1, beat0} >> {offset, 3'b000});
    case (funct3[1:0])
      2'b00:   result = funct3[2] ? XLEN'(merged[7:0])  : XLEN'($signed(merged[7:0]));
      2'b01:   result = funct3[2] ? XLEN'(merged[15:0]) : XLEN'($signed(merged[15:0]));
      2'b10:   result = funct3[2] ? XLEN'(merged[31:0]) : XLEN'($signed(merged[31:0]));
      default: result = merged;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multicycle load/store unit with optional split of misaligned accesses.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned XLEN             = 32,
  parameter int unsigned ADDR_W           = 32,
  parameter int unsigned MISALIGNED_SPLIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [XLEN-1:0]   rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready
);
  localparam int unsigned BYTES = XLEN / 8;
  localparam int unsigned OFFW  = $clog2(BYTES);
  localparam int unsigned BEW   = 2 * BYTES;
  localparam int unsigned WDW   = 2 * XLEN;

  state_t          state_q, state_d;
  logic            write_q, split_q;
  logic [2:0]      funct3_q;
  logic [OFFW-1:0] offset_q;
  logic [BYTES-1:0] be1_q;
  logic [XLEN-1:0] wdata1_q, beat0_q;

  logic [OFFW-1:0] offset_c;
  int unsigned     size_c;
  logic            fits_c, legal_c, go_c;
  logic [BEW-1:0]  be_c;
  logic [WDW-1:0]  wd_c;
  logic [XLEN-1:0] lx_beat0, load_result;

  // Request decode: the upper half of be_c/wd_c is what spills into the second beat
  always_comb begin
    offset_c = addr[OFFW-1:0];
    size_c   = access_size(funct3);
    fits_c   = (32'(offset_c) + size_c) <= BYTES;
    legal_c  = is_legal(funct3, write, XLEN);
    go_c     = legal_c && (fits_c || (MISALIGNED_SPLIT != 0));
    be_c     = BEW'((32'd1 << size_c) - 32'd1) << offset_c;
    wd_c     = {XLEN'(0), wdata} << {offset_c, 3'b000};
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = go_c ? ST_BEAT0 : ST_DONE;
      ST_BEAT0: if (mem_ready) state_d = split_q ? ST_BEAT1 : ST_DONE;
      ST_BEAT1: if (mem_ready) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // First beat's data comes straight off the bus; in a split it was captured earlier
  assign lx_beat0 = (state_q == ST_BEAT0) ? mem_rdata : beat0_q;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .beat0  (lx_beat0),
    .beat1  (mem_rdata),
    .offset (offset_q),
    .funct3 (funct3_q),
    .result (load_result)
  );

  // Registered outputs and request capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      write_q   <= 1'b0;
      split_q   <= 1'b0;
      funct3_q  <= '0;
      offset_q  <= '0;
      be1_q     <= '0;
      wdata1_q  <= '0;
      beat0_q   <= '0;
    end else begin
      busy    <= (state_d != ST_IDLE);
      done    <= (state_d == ST_DONE);
      mem_req <= (state_d == ST_BEAT0) || (state_d == ST_BEAT1);
      case (state_q)
        ST_IDLE: if (start) begin
          write_q   <= write;
          funct3_q  <= funct3;
          offset_q  <= offset_c;
          split_q   <= !fits_c;
          fault     <= !go_c;
          mem_we    <= write;
          mem_addr  <= {addr[ADDR_W-1:OFFW], OFFW'(0)};
          mem_be    <= be_c[BYTES-1:0];
          mem_wdata <= wd_c[XLEN-1:0];
          be1_q     <= be_c[BEW-1:BYTES];
          wdata1_q  <= wd_c[WDW-1:XLEN];
        end
        ST_BEAT0: if (mem_ready) begin
          beat0_q <= mem_rdata;
          if (split_q) begin
            mem_addr  <= mem_addr + ADDR_W'(BYTES);
            mem_be    <= be1_q;
            mem_wdata <= wdata1_q;
          end else if (!write_q) begin
            rdata <= load_result;
          end
        end
        ST_BEAT1: if (mem_ready && !write_q) rdata <= load_result;
        ST_DONE:  fault <= 1'b0;
        default:  ;
      endcase
    end
  end

endmodule
